// File: rtl/dot_matrix_scan_pkg.sv
// Shared definitions for the dot-matrix row scanner: FSM state encoding,
// default row timings and the row-select decode used by the top and pattern ROMs.
package dot_matrix_scan_pkg;

    localparam int unsigned DEF_SHOW_CYC  = 1000;
    localparam int unsigned DEF_BLANK_CYC = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHOW,
        BLANK
    } scan_state_t;

    function automatic logic [15:0] row_onehot(input logic [3:0] row);
        return 16'h0001 << row;
    endfunction

endpackage

// File: rtl/dot_matrix_scan_timer.sv
// Loadable 16-bit down-counter; done is high while the count sits at zero.
// Loading N gives N+1 cycles from the load edge until done would retrigger.
module scan_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 16'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/dot_matrix_scan.sv
// 16-row dot-matrix scanner: fetch a row bitmap from an external ROM, light the
// row for SHOW_CYC cycles, then blank for BLANK_CYC cycles before the next row.
module dot_matrix_scan
    import dot_matrix_scan_pkg::*;
#(
    parameter int unsigned SHOW_CYC  = DEF_SHOW_CYC,
    parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] col_in,
    output logic [3:0]  row_bin,
    output logic [15:0] row_drv,
    output logic [15:0] col_drv,
    output logic        frame_done
);

    localparam logic [15:0] SHOW_LOAD  = 16'(SHOW_CYC - 1);
    localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYC - 1);
    localparam logic [3:0]  LAST_ROW   = 4'd15;

    scan_state_t state;
    logic [3:0]  row;
    logic        tmr_load;
    logic [15:0] tmr_val;
    logic        tmr_done;

    // Timer is reloaded on every state entry; done in the final cycle of a state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!en) begin
            tmr_load = 1'b1;
        end else begin
            case (state)
                IDLE:  tmr_load = 1'b1;
                FETCH: begin
                    tmr_load = 1'b1;
                    tmr_val  = SHOW_LOAD;
                end
                SHOW: if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LOAD;
                end
                BLANK: tmr_load = tmr_done;
                default: tmr_load = 1'b1;
            endcase
        end
    end

    scan_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            row_drv    <= '0;
            col_drv    <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            row        <= '0;
            row_drv    <= '0;
            col_drv    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    // col_drv doubles as the latched bitmap for the whole SHOW phase
                    row_drv <= row_onehot(row);
                    col_drv <= col_in;
                    state   <= SHOW;
                end
                SHOW: if (tmr_done) begin
                    row_drv <= '0;
                    col_drv <= '0;
                    state   <= BLANK;
                end
                BLANK: if (tmr_done) begin
                    row        <= row + 4'd1;
                    frame_done <= (row == LAST_ROW);
                    state      <= FETCH;
                end
                default: begin
                    row_drv <= '0;
                    col_drv <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign row_bin = row;

endmodule
